// File: rtl/lab_iram_loader.sv
// lab_iram_loader: writable instruction memory for the lab single-cycle CPU.
//
// The array holds DEPTH words of DATA_W bits. After reset, a sweep writes
// CLEAR_WORD to every word. The array is then loaded through a byte-serial
// port. The CPU fetches with a byte address, as it did from the old ROM.
//
// Ports:
//   CLK, RESET  clock (rising edge) and synchronous active-high reset
//   ADDR        fetch byte address; word index = ADDR[ADDR_W-1:log2(BPW)]
//   Q           fetched word; 0 while busy or when the index is out of range
//   MISALIGN    byte-offset bits of ADDR are non-zero
//   LD_START    one-cycle pulse: (re)start a load at word 0
//   LD_VALID    LD_DATA carries a byte this cycle
//   LD_DATA     program byte, most-significant byte of each word first
//   LD_LAST     marks the final byte of the load (qualified by LD_VALID)
//   LD_READY    loader accepts a byte this cycle
//   BUSY        clear sweep or load in progress
//   LD_DONE     one-cycle pulse after the LD_LAST byte is accepted
//   LD_ERR      sticky overflow flag (bytes arrived after the last word)
//   DBG_STATE   FSM state: 0 = CLEAR, 1 = IDLE, 2 = LOAD
//
// Handshake: a byte transfers on a rising edge where LD_VALID && LD_READY are
// both high. LD_READY does not depend on LD_VALID. The source holds LD_DATA and
// LD_LAST stable while LD_VALID is high. If LD_START is high in the same cycle,
// it takes priority and that byte is discarded.
module lab_iram_loader #(
  parameter int              ADDR_W     = 8,
  parameter int              DATA_W     = 16,
  parameter int              DEPTH      = 128,
  parameter int              REG_OUT    = 0,
  parameter logic [DATA_W-1:0] CLEAR_WORD = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              MISALIGN,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              BUSY,
  output logic              LD_DONE,
  output logic              LD_ERR,
  output logic [1:0]        DBG_STATE
);

  localparam int BPW   = DATA_W / 8;
  localparam int LSB_W = $clog2(BPW);
  localparam int IDX_W = ADDR_W - LSB_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = AW + 1;                    // word pointer reaches DEPTH
  localparam int CW    = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     clr_ptr_q;
  logic [PW-1:0]     wptr_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] asm_q;
  logic              ld_done_q;
  logic              ld_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              full;
  logic              word_end;
  logic              ld_wr;
  logic              clr_wr;
  int                byte_sh;
  logic [DATA_W-1:0] word_next;

  assign LD_READY  = (state_q == S_LOAD);
  assign BUSY      = (state_q != S_IDLE);
  assign LD_DONE   = ld_done_q;
  assign LD_ERR    = ld_err_q;
  assign DBG_STATE = state_q;

  assign accept   = LD_READY && LD_VALID && !LD_START;
  assign full     = (wptr_q == PW'(DEPTH));
  assign word_end = (cnt_q == CW'(BPW - 1));

  // Each byte is OR-ed straight into its final lane. This means a partial
  // word closed by LD_LAST is already zero-filled in its low bytes.
  always_comb begin
    byte_sh   = 8 * (BPW - 1 - int'(cnt_q));
    word_next = asm_q | (DATA_W'(LD_DATA) << byte_sh);
  end

  assign clr_wr = !RESET && (state_q == S_CLEAR);
  assign ld_wr  = !RESET && accept && !full && (word_end || LD_LAST);

  always_ff @(posedge CLK) begin
    if (clr_wr) begin
      mem[clr_ptr_q] <= CLEAR_WORD;
    end else if (ld_wr) begin
      mem[wptr_q[AW-1:0]] <= word_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == AW'(DEPTH - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (LD_START) begin
            state_q  <= S_LOAD;
            wptr_q   <= '0;
            cnt_q    <= '0;
            asm_q    <= '0;
            ld_err_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (LD_START) begin
            wptr_q   <= '0;
            cnt_q    <= '0;
            asm_q    <= '0;
            ld_err_q <= 1'b0;
          end else if (LD_VALID) begin
            if (full) begin
              // Array exhausted: drop the byte but keep draining to LD_LAST.
              ld_err_q <= 1'b1;
            end else if (word_end || LD_LAST) begin
              wptr_q <= wptr_q + 1'b1;
              cnt_q  <= '0;
              asm_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              asm_q <= word_next;
            end
            if (LD_LAST) begin
              state_q   <= S_IDLE;
              ld_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Fetch path
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] q_c;
  logic              mis_c;

  assign idx      = ADDR[ADDR_W-1:LSB_W];
  assign in_range = ({1'b0, idx} < (IDX_W + 1)'(DEPTH));
  assign q_c      = (state_q == S_IDLE && in_range) ? mem[idx[AW-1:0]] : '0;

  if (LSB_W > 0) begin : g_mis
    assign mis_c = |ADDR[LSB_W-1:0];
  end else begin : g_nomis
    assign mis_c = 1'b0;
  end

  if (REG_OUT != 0) begin : g_reg
    logic [DATA_W-1:0] q_r;
    logic              mis_r;
    always_ff @(posedge CLK) begin
      if (RESET) begin
        q_r   <= '0;
        mis_r <= 1'b0;
      end else begin
        q_r   <= q_c;
        mis_r <= mis_c;
      end
    end
    assign Q        = q_r;
    assign MISALIGN = mis_r;
  end else begin : g_comb
    assign Q        = q_c;
    assign MISALIGN = mis_c;
  end

endmodule

// File: tb/tb_lab_iram_loader.sv
// tb_lab_iram_loader: three loader instances driven from one stimulus stream.
//   u_a : default parameters (combinational fetch, DEPTH=128)
//   u_b : DEPTH=4 (overflow behaviour)
//   u_r : REG_OUT=1 (registered fetch)
module tb_lab_iram_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  addr = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;

  logic [15:0] q_a, q_b, q_r;
  logic        mis_a, mis_b, mis_r;
  logic        ready_a, ready_b, ready_r;
  logic        busy_a, busy_b, busy_r;
  logic        done_a, done_b, done_r;
  logic        err_a, err_b, err_r;
  logic [1:0]  st_a, st_b, st_r;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  lab_iram_loader u_a (
    .CLK(clk), .RESET(reset), .ADDR(addr), .Q(q_a), .MISALIGN(mis_a),
    .LD_START(ld_start), .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_LAST(ld_last),
    .LD_READY(ready_a), .BUSY(busy_a), .LD_DONE(done_a), .LD_ERR(err_a), .DBG_STATE(st_a)
  );

  lab_iram_loader #(.DEPTH(4)) u_b (
    .CLK(clk), .RESET(reset), .ADDR(addr), .Q(q_b), .MISALIGN(mis_b),
    .LD_START(ld_start), .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_LAST(ld_last),
    .LD_READY(ready_b), .BUSY(busy_b), .LD_DONE(done_b), .LD_ERR(err_b), .DBG_STATE(st_b)
  );

  lab_iram_loader #(.REG_OUT(1)) u_r (
    .CLK(clk), .RESET(reset), .ADDR(addr), .Q(q_r), .MISALIGN(mis_r),
    .LD_START(ld_start), .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_LAST(ld_last),
    .LD_READY(ready_r), .BUSY(busy_r), .LD_DONE(done_r), .LD_ERR(err_r), .DBG_STATE(st_r)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] qa;    // expected word for the DEPTH=128 instances
    logic [15:0] qb;    // expected word for the DEPTH=4 instance
    logic        mis;
  } vec_t;

  vec_t vt[8];
  int   nv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: each begins at a falling edge
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_start = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("state_in_reset", st_a, ST_CLEAR);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Count BUSY cycles of each instance from the current falling edge onward.
  task automatic sweep(input int exp_a, input int exp_b);
    int ca, cb, cr, cd;
    ca = 0; cb = 0; cr = 0; cd = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (busy_r) cr++;
      if (done_a || done_b || done_r) cd++;
      if (!busy_a && !busy_b && !busy_r) break;
      @(negedge clk);
    end
    check("sweep_busy_a", ca, exp_a);
    check("sweep_busy_b", cb, exp_b);
    check("sweep_busy_r", cr, exp_a);
    check("sweep_no_done", cd, 0);
    check("sweep_idle_state", st_a, ST_IDLE);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] ea, input logic [15:0] eb,
                       input logic em);
    @(negedge clk);
    addr = a;
    #1;
    check("q_comb", q_a, ea);
    check("mis_comb", mis_a, em);
    check("q_depth4", q_b, eb);
    @(posedge clk);
    #1;
    check("q_reg", q_r, ea);
    check("mis_reg", mis_r, em);
  endtask

  task automatic run_table();
    for (int i = 0; i < nv; i++) fetch(vt[i].addr, vt[i].qa, vt[i].qb, vt[i].mis);
  endtask

  task automatic check_all_zero();
    for (int a = 0; a < 256; a += 2) fetch(8'(a), 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    // 1: reset and clear sweep
    do_reset(2);
    check("rst_busy", busy_a, 1);
    check("rst_ready", ready_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_q_comb", q_a, 0);
    check("rst_q_reg", q_r, 0);
    sweep(128, 4);
    check_all_zero();

    // 2: program load, back-to-back bytes
    pulse_start();
    check("load_state", st_a, ST_LOAD);
    check("load_busy", busy_a, 1);
    check("load_ready", ready_a, 1);
    drive_byte(8'hF0, 0);
    drive_byte(8'h01, 0);
    drive_byte(8'h20, 0);
    drive_byte(8'h78, 0);
    drive_byte(8'h50, 0);
    #1 check("no_early_done", done_a, 0);
    drive_byte(8'h80, 1);
    idle_cycle();
    #1;
    check("done_pulse_a", done_a, 1);
    check("done_pulse_b", done_b, 1);
    check("done_state", st_a, ST_IDLE);
    check("done_busy", busy_a, 0);
    @(negedge clk);
    #1 check("done_one_cycle", done_a, 0);
    nv = 7;
    vt[0] = '{8'h00, 16'hF001, 16'hF001, 1'b0};
    vt[1] = '{8'h02, 16'h2078, 16'h2078, 1'b0};
    vt[2] = '{8'h04, 16'h5080, 16'h5080, 1'b0};
    vt[3] = '{8'h06, 16'h0000, 16'h0000, 1'b0};
    vt[4] = '{8'h01, 16'hF001, 16'hF001, 1'b1};
    vt[5] = '{8'h05, 16'h5080, 16'h5080, 1'b1};
    vt[6] = '{8'h08, 16'h0000, 16'h0000, 1'b0};
    run_table();

    // 3: partial final word with gaps between bytes
    pulse_start();
    drive_byte(8'h12, 0);
    for (int g = 0; g < 3; g++) begin
      idle_cycle();
      #1 check("gap_ready", ready_a, 1);
    end
    drive_byte(8'h34, 0);
    for (int g = 0; g < 3; g++) begin
      idle_cycle();
      #1 check("gap_done", done_a, 0);
    end
    drive_byte(8'hAB, 1);
    idle_cycle();
    #1 check("partial_done", done_a, 1);
    nv = 4;
    vt[0] = '{8'h00, 16'h1234, 16'h1234, 1'b0};
    vt[1] = '{8'h02, 16'hAB00, 16'hAB00, 1'b0};
    vt[2] = '{8'h04, 16'h5080, 16'h5080, 1'b0};
    vt[3] = '{8'h06, 16'h0000, 16'h0000, 1'b0};
    run_table();

    // 4: overflow on the DEPTH=4 instance
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      drive_byte(8'hA0 + 8'(i), (i == 9));
      #1 check("ovf_err_progress", err_b, (i >= 9));
    end
    idle_cycle();
    #1;
    check("ovf_err_b", err_b, 1);
    check("ovf_err_a", err_a, 0);
    check("ovf_done_b", done_b, 1);
    check("ovf_state_b", st_b, ST_IDLE);
    nv = 6;
    vt[0] = '{8'h00, 16'hA0A1, 16'hA0A1, 1'b0};
    vt[1] = '{8'h02, 16'hA2A3, 16'hA2A3, 1'b0};
    vt[2] = '{8'h04, 16'hA4A5, 16'hA4A5, 1'b0};
    vt[3] = '{8'h06, 16'hA6A7, 16'hA6A7, 1'b0};
    vt[4] = '{8'h08, 16'hA8A9, 16'h0000, 1'b0};
    vt[5] = '{8'h0A, 16'h0000, 16'h0000, 1'b0};
    run_table();
    #1 check("err_sticky", err_b, 1);
    pulse_start();
    #1 check("err_cleared", err_b, 0);

    // 5: reset in the middle of a load
    drive_byte(8'h11, 0);
    drive_byte(8'h22, 0);
    drive_byte(8'h33, 0);
    do_reset(1);
    check("midrst_busy", busy_a, 1);
    check("midrst_ready", ready_a, 0);
    check("midrst_err", err_b, 0);
    sweep(128, 4);
    check_all_zero();

    // 6: registered fetch latency and misalignment
    @(negedge clk);
    addr = 8'h00;
    pulse_start();
    drive_byte(8'h11, 0);
    drive_byte(8'h22, 0);
    drive_byte(8'h33, 0);
    drive_byte(8'h44, 1);
    idle_cycle();
    #1;
    check("r_done", done_r, 1);
    check("r_comb_q_now", q_a, 16'h1122);
    check("r_q_sampled_busy", q_r, 16'h0000);
    @(posedge clk);
    #1 check("r_q_after_idle", q_r, 16'h1122);
    @(negedge clk);
    addr = 8'h03;
    #1;
    check("r_q_old", q_r, 16'h1122);
    check("r_mis_old", mis_r, 0);
    check("c_mis_03", mis_a, 1);
    check("c_q_03", q_a, 16'h3344);
    @(posedge clk);
    #1;
    check("r_q_03", q_r, 16'h3344);
    check("r_mis_03", mis_r, 1);
    @(negedge clk);
    addr = 8'h04;
    #1 check("r_mis_hold", mis_r, 1);
    @(posedge clk);
    #1;
    check("r_mis_04", mis_r, 0);
    check("r_q_04", q_r, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab_iram_loader.md
Name: lab_iram_loader

Overview:
- Parametrised instruction memory for the lab single-cycle CPU.
- Replaces the reset-initialised fixed-program ROM with a writable array of DEPTH words.
- After reset the array is cleared by a sequential sweep; it is then loaded at runtime through a byte-serial valid/ready port.
- The CPU fetch path reads it with a byte address, exactly like the previous instruction ROM.

Parameters:
- ADDR_W, 8: byte-address width of the fetch port.
- DATA_W, 16: instruction width. Must be a multiple of 8; BPW = DATA_W/8 bytes per word.
- DEPTH, 128: number of instruction words. Must satisfy DEPTH <= 2^(ADDR_W - log2(BPW)).
- REG_OUT, 0: 0 = combinational fetch read; 1 = registered fetch read with 1-cycle latency.
- CLEAR_WORD, 0: value written to every word during the clear sweep (all zeros = NOP encoding).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  ADDR_W  fetch byte address. Word index = ADDR[ADDR_W-1:log2(BPW)].
- Q  out  DATA_W  fetched instruction.
- MISALIGN  out  1  high when ADDR[log2(BPW)-1:0] != 0. Combinational; registered with Q when REG_OUT=1.
- LD_START  in  1  one-cycle pulse; begins a load at word 0.
- LD_VALID  in  1  LD_DATA is valid this cycle.
- LD_DATA  in  8  program byte, most-significant byte of each word first.
- LD_LAST  in  1  qualifies the final byte of the load; sampled with LD_VALID.
- LD_READY  out  1  loader accepts a byte this cycle.
- BUSY  out  1  clear sweep or load in progress.
- LD_DONE  out  1  one-cycle pulse when a load completes.
- LD_ERR  out  1  sticky; set when a byte arrives after word DEPTH-1 has been written. Cleared by RESET or LD_START.

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high.
- FSM states: CLEAR, IDLE, LOAD.
- RESET (at any time, including mid-sweep or mid-load):
  - state <= CLEAR, sweep pointer <= 0, byte counter <= 0, word pointer <= 0.
  - LD_ERR <= 0, LD_DONE <= 0.
  - Registered Q <= 0.
  - Memory contents are not guaranteed until the sweep finishes.
- CLEAR:
  - Writes CLEAR_WORD to mem[ptr] each cycle, ptr increments by 1.
  - After writing DEPTH-1, goes to IDLE; the sweep takes exactly DEPTH cycles after reset deasserts.
  - BUSY=1, LD_READY=0. LD_START is ignored.
- IDLE:
  - BUSY=0, LD_READY=0.
  - LD_START -> LOAD with word pointer 0, byte counter 0, assembly register 0, LD_ERR <= 0.
- LOAD:
  - BUSY=1, LD_READY=1.
  - Byte accepted when LD_VALID && LD_READY. It is shifted into the assembly register; the first byte lands in bits [DATA_W-1:DATA_W-8].
  - When the BPW-th byte of a word is accepted, the word is written to mem[word pointer] at that clock edge, the pointer increments, and the byte counter resets.
  - LD_LAST on a partial word: the remaining low bytes are zero-filled and the word is written at that edge.
  - LD_LAST accepted -> IDLE next cycle, with LD_DONE=1 for exactly that one cycle.
  - Bytes accepted after word DEPTH-1 has been written are dropped and LD_ERR is set. The loader stays in LOAD until LD_LAST.
  - LD_START while in LOAD restarts the load from word 0.
- Fetch path:
  - Q = mem[word index] when the state is IDLE and word index < DEPTH; otherwise Q = 0.
  - Out-of-range words read 0; this includes the whole array during CLEAR and LOAD.
  - REG_OUT=1: Q and MISALIGN are registered, giving 1-cycle latency from ADDR. Q is 0 in the cycle after BUSY falls only if the address was sampled while busy.
- Write-then-read ordering: a word written at edge N is visible on Q (REG_OUT=0) from cycle N+1.
- No write path other than the clear sweep and the loader exists.

Test Plan:
1. Reset sweep: hold RESET 2 cycles with DEPTH=128 -> BUSY=1 for exactly 128 cycles after RESET falls; then Q=0000 for every ADDR 0x00..0xFE.
2. Program load: LD_START, then bytes F0,01,20,78,50,80 with LD_LAST on the last byte -> LD_DONE pulses one cycle after the final byte; ADDR=0x00 gives Q=F001, 0x02 gives 2078, 0x04 gives 5080, 0x06 gives 0000.
3. Partial word plus backpressure: load bytes 12,34,AB with LD_LAST on AB, and LD_VALID gapped 3 cycles between bytes -> mem[1]=AB00; the gaps add no spurious writes.
4. Overflow: with DEPTH=4, stream 10 bytes -> words 0..3 are written, LD_ERR=1 after byte 9, LD_DONE still pulses; a subsequent LD_START clears LD_ERR.
5. Reset mid-load: assert RESET after 3 bytes -> state is CLEAR, BUSY stays high for DEPTH cycles, all words read 0000, LD_DONE never pulses.
6. Misalign and REG_OUT=1: ADDR=0x03 -> MISALIGN=1 and Q=mem[1], both appearing one cycle after ADDR is applied; ADDR=0x04 -> MISALIGN=0.
